// File: rtl/xbus_timer.sv
// xbus_timer -- prescaled 32-bit compare timer with one-shot/periodic modes and level irq.
// Revision: 1.0
`default_nettype none

`ifndef XDATAW
`define XDATAW 32
`endif
`ifndef XBYTEC
`define XBYTEC 4
`endif
`ifndef XADDRW
`define XADDRW 32
`endif

module xbus_timer #(
  parameter int PRESC_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 xbus_cs,
  input  logic                 xbus_we,
  input  logic [`XBYTEC-1:0]   xbus_be,
  input  logic [`XADDRW-1:0]   xbus_addr,
  input  logic [`XDATAW-1:0]   xbus_wdata,
  output logic [`XDATAW-1:0]   xbus_rdata,
  output logic                 irq
);

  localparam logic [2:0] c_OFF_CTRL   = 3'd0;
  localparam logic [2:0] c_OFF_PRESC  = 3'd1;
  localparam logic [2:0] c_OFF_COUNT  = 3'd2;
  localparam logic [2:0] c_OFF_CMP    = 3'd3;
  localparam logic [2:0] c_OFF_STATUS = 3'd4;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  logic [2:0]         ctrl_q, ctrl_d;     // {IRQ_EN, AUTO, EN}
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [31:0]        count_q, count_d;
  logic [31:0]        cmp_q, cmp_d;
  logic               match_q, match_d;
  logic [31:0]        rdata_q, rdata_d;

  logic        w_wr;
  logic        w_rd;
  logic [2:0]  w_sel;
  logic        w_tick;
  logic        w_hit;
  logic [31:0] w_presc_ext;
  logic        unused_addr_bits;

  assign w_wr   = xbus_cs & xbus_we;
  assign w_rd   = xbus_cs & ~xbus_we;
  assign w_sel  = xbus_addr[4:2];
  assign w_tick = ctrl_q[0] && (pcnt_q == presc_q);
  assign w_hit  = w_tick && (count_q == cmp_q);
  assign unused_addr_bits = ^{xbus_addr[`XADDRW-1:5], xbus_addr[1:0]};

  always_comb begin
    w_presc_ext = '0;
    w_presc_ext[PRESC_W-1:0] = presc_q;
  end

  always_comb begin
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    match_d = match_q;
    rdata_d = rdata_q;

    if (!ctrl_q[0] || w_tick) pcnt_d = '0;
    else                      pcnt_d = pcnt_q + PRESC_W'(1);

    if (w_tick) begin
      if (w_hit) begin
        match_d = 1'b1;
        if (ctrl_q[1]) count_d   = '0;
        else           ctrl_d[0] = 1'b0;
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    // Software writes are applied on top of the tick update so they win.
    if (w_wr) begin
      case (w_sel)
        c_OFF_CTRL:   if (xbus_be[0]) ctrl_d = xbus_wdata[2:0];
        c_OFF_PRESC: begin
          for (int b = 0; b < PRESC_W; b++) begin
            if (xbus_be[b/8]) presc_d[b] = xbus_wdata[b];
          end
          pcnt_d = '0;
        end
        c_OFF_COUNT:  count_d = f_merge(count_d, xbus_wdata, xbus_be);
        c_OFF_CMP:    cmp_d   = f_merge(cmp_q, xbus_wdata, xbus_be);
        c_OFF_STATUS: if (xbus_be[0] && xbus_wdata[0] && !w_hit) match_d = 1'b0;
        default: ;
      endcase
    end

    if (w_rd) begin
      case (w_sel)
        c_OFF_CTRL:   rdata_d = {29'd0, ctrl_q};
        c_OFF_PRESC:  rdata_d = w_presc_ext;
        c_OFF_COUNT:  rdata_d = count_q;
        c_OFF_CMP:    rdata_d = cmp_q;
        c_OFF_STATUS: rdata_d = {31'd0, match_q};
        default:      rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      presc_q <= '0;
      pcnt_q  <= '0;
      count_q <= '0;
      cmp_q   <= '0;
      match_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      rdata_q <= rdata_d;
    end
  end

  assign xbus_rdata = rdata_q;
  assign irq        = match_q & ctrl_q[2];

endmodule

`default_nettype wire

// File: tb/tb_xbus_timer.sv
// tb_xbus_timer -- scoreboard bench for xbus_timer register map, counting modes and reset.
// Revision: 1.0
`default_nettype none

`ifndef XDATAW
`define XDATAW 32
`endif
`ifndef XBYTEC
`define XBYTEC 4
`endif
`ifndef XADDRW
`define XADDRW 32
`endif

module tb_xbus_timer;

  localparam logic [31:0] c_CTRL   = 32'h00;
  localparam logic [31:0] c_PRESC  = 32'h04;
  localparam logic [31:0] c_COUNT  = 32'h08;
  localparam logic [31:0] c_CMP    = 32'h0C;
  localparam logic [31:0] c_STATUS = 32'h10;

  logic                 clk;
  logic                 rst;
  logic                 xbus_cs;
  logic                 xbus_we;
  logic [`XBYTEC-1:0]   xbus_be;
  logic [`XADDRW-1:0]   xbus_addr;
  logic [`XDATAW-1:0]   xbus_wdata;
  logic [`XDATAW-1:0]   xbus_rdata;
  logic                 irq;

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  xbus_timer #(.PRESC_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .xbus_cs    (xbus_cs),
    .xbus_we    (xbus_we),
    .xbus_be    (xbus_be),
    .xbus_addr  (xbus_addr),
    .xbus_wdata (xbus_wdata),
    .xbus_rdata (xbus_rdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Read data appears one edge after the request; compare it against the oldest pushed expectation.
  always @(posedge clk) begin
    if (xbus_cs && !xbus_we && !rst) begin
      #1;
      check_val("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check_val(tag_q.pop_front(), xbus_rdata, exp_q.pop_front());
    end
  end

  // All bus tasks start and end at a negedge.
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    xbus_cs = 1'b1; xbus_we = 1'b1; xbus_addr = a; xbus_wdata = d; xbus_be = be;
    @(negedge clk);
    xbus_cs = 1'b0; xbus_we = 1'b0; xbus_be = '0;
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    xbus_cs = 1'b1; xbus_we = 1'b0; xbus_addr = a;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    xbus_cs = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 0x%08h expected 0x%08h", 32'd0, 32'd1);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    rst = 1'b1; xbus_cs = 1'b0; xbus_we = 1'b0; xbus_be = '0;
    xbus_addr = '0; xbus_wdata = '0;
    do_reset();

    // Reset readback of every offset, then an ignored write to a hole.
    check_val("rst_rdata", xbus_rdata, 32'd0);
    check_val("rst_irq", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 8; i++) bus_rd(32'(i * 4), 32'd0, "rst_read");
    bus_wr(32'h18, 32'hFFFF_FFFF, 4'hF);
    bus_rd(32'h18, 32'd0, "hole_read");
    bus_rd(c_CTRL, 32'd0, "hole_no_alias");

    // Periodic: a tick every 4 clk, COUNT 0,1,2,0 with MATCH on the 3rd tick.
    bus_wr(c_PRESC, 32'd3, 4'hF);
    bus_rd(c_PRESC, 32'd3, "presc_read");
    bus_wr(c_CMP, 32'd2, 4'hF);
    bus_wr(c_CTRL, 32'h7, 4'hF);
    for (int k = 1; k <= 14; k++) begin
      t = (k - 1) / 4;
      bus_rd(c_COUNT, (t == 3) ? 32'd0 : 32'(t), "per_count");
      check_val("per_irq", {31'd0, irq}, (k >= 12) ? 32'd1 : 32'd0);
    end
    bus_rd(c_STATUS, 32'd1, "per_status");
    bus_rd(c_CTRL, 32'h7, "per_ctrl_kept");

    // One-shot with PRESC=0: tick every clk, stop at CMP, EN self-clears.
    do_reset();
    bus_wr(c_CMP, 32'd5, 4'hF);
    bus_wr(c_CTRL, 32'h1, 4'hF);
    for (int k = 1; k <= 8; k++) bus_rd(c_COUNT, (k - 1 > 5) ? 32'd5 : 32'(k - 1), "os_count");
    bus_rd(c_CTRL, 32'd0, "os_ctrl");
    bus_rd(c_STATUS, 32'd1, "os_status");
    bus_rd(c_COUNT, 32'd5, "os_count_held");
    check_val("os_irq", {31'd0, irq}, 32'd0);

    // Wrap-around from all-ones without a match.
    do_reset();
    bus_wr(c_CMP, 32'h10, 4'hF);
    bus_wr(c_COUNT, 32'hFFFF_FFFF, 4'hF);
    bus_wr(c_CTRL, 32'h1, 4'hF);
    bus_rd(c_COUNT, 32'hFFFF_FFFF, "wrap_pre");
    bus_rd(c_COUNT, 32'd0, "wrap_zero");
    bus_rd(c_COUNT, 32'd1, "wrap_one");
    bus_rd(c_STATUS, 32'd0, "wrap_status");

    // W1C racing a match: set wins; write-0 is a no-op; a later write-1 clears.
    do_reset();
    bus_wr(c_CMP, 32'd3, 4'hF);
    bus_wr(c_CTRL, 32'h5, 4'hF);
    repeat (3) @(negedge clk);
    bus_wr(c_STATUS, 32'd1, 4'hF);
    bus_rd(c_STATUS, 32'd1, "race_status");
    check_val("race_irq", {31'd0, irq}, 32'd1);
    bus_wr(c_STATUS, 32'd0, 4'hF);
    bus_rd(c_STATUS, 32'd1, "w0_status");
    bus_wr(c_STATUS, 32'd1, 4'hF);
    bus_rd(c_STATUS, 32'd0, "clr_status");
    check_val("clr_irq", {31'd0, irq}, 32'd0);

    // Byte enables, then reset abandoning a running count.
    do_reset();
    bus_wr(c_CMP, 32'hAABB_CCDD, 4'b0101);
    bus_rd(c_CMP, 32'h00BB_00DD, "be_cmp");
    bus_wr(c_PRESC, 32'd2, 4'hF);
    bus_wr(c_CTRL, 32'h7, 4'hF);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("mid_rst_rdata", xbus_rdata, 32'd0);
    check_val("mid_rst_irq", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 8; i++) bus_rd(32'(i * 4), 32'd0, "mid_rst_read");
    repeat (10) @(negedge clk);
    bus_rd(c_COUNT, 32'd0, "post_rst_count");
    bus_rd(c_STATUS, 32'd0, "post_rst_status");
    check_val("post_rst_irq", {31'd0, irq}, 32'd0);

    @(negedge clk);
    check_val("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

`default_nettype wire
